// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: loader state
// encoding and stream framing constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a little-endian byte stream into instruction words. byte_last flags
// that the byte being offered now completes a word; word_valid pulses one
// cycle later with the finished word on 'word'.
module imem_word_assembler
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic                  byte_last,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;

  assign byte_last = (cnt_q == 2'(BYTES_PER_WORD - 1));

  // Insert each byte into its lane; every lane is overwritten per word, so no clear is needed
  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (byte_en) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_data;
      cnt_d   = cnt_q + 2'd1;
      valid_d = byte_last;
    end
  end

  // Lane counter, word register and completion strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_valid = valid_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Program loader on the write side of the instruction memory. Takes a
// length-prefixed byte stream, writes words from address 0 upward and keeps
// the core in reset until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte before the core is released.
//
// state  | meaning
// S_LEN0 | waiting for word count low byte
// S_LEN1 | waiting for word count high byte
// S_DATA | receiving image bytes
// S_CSUM | waiting for checksum byte (checksum builds only)
// S_DONE | image complete, core released
// S_ERR  | oversize image or bad checksum, core held in reset
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_AFTER = S_CSUM;
`else
  localparam state_e S_AFTER = S_DONE;
`endif

  state_e                 state_q, state_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   byte_ready_q, byte_ready_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   load_done_q, load_done_d;
  logic                   load_error_q, load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  logic                 xfer;
  logic                 asm_en;
  logic                 asm_last;
  logic [LEN_WIDTH-1:0] len_full;

  assign xfer     = byte_valid & byte_ready_q;
  assign asm_en   = xfer && (state_q == S_DATA);
  assign len_full = {byte_data, len_lo_q};

  imem_word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .byte_en   (asm_en),
    .byte_data (byte_data),
    .byte_last (asm_last),
    .word_valid(imem_we),
    .word      (imem_wdata)
  );

  // Next-state, remaining-word down-counter, address and status decode
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    addr_d   = imem_we ? addr_q + ADDR_WIDTH'(1) : addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = xfer ? (csum_q ^ byte_data) : csum_q;
`endif
    case (state_q)
      S_LEN0: begin
        if (xfer) begin
          len_lo_d = byte_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          rem_d = len_full;
          if ({1'b0, len_full} > MAX_WORDS) state_d = S_ERR;
          else if (len_full == '0)          state_d = S_AFTER;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && asm_last) begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = S_AFTER;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
    byte_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    // Status follows the state register, so it lags the final byte/write by one cycle
    load_done_d  = (state_q == S_DONE);
    core_rst_n_d = (state_q == S_DONE);
    load_error_d = (state_q == S_ERR);
  end

  // State and registered outputs; reset abandons any partial image
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_LEN0;
      len_lo_q     <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      byte_ready_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      byte_ready_q <= byte_ready_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_addr  = addr_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-count based reference model predicts every
// output each cycle, plus literal checks on the documented example streams.
module tb_imem_loader;

  localparam int AW   = 8;
  localparam int MAXW = 2 ** AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_error;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: everything follows from the list of accepted bytes.
  bit            m_started = 1'b0;
  logic [7:0]    m_rx[$];
  logic [7:0]    m_xor;
  bit            m_term, m_err, m_ready;
  bit            e_we, e_done, e_err, e_inrst;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;

  always @(posedge clk) begin : model
    bit xfer;
    int n, nw, total;
    m_started = 1'b1;
    if (!rst) begin
      m_rx.delete();
      m_xor = 8'h00; m_term = 0; m_err = 0; m_ready = 0;
      e_we = 0; e_done = 0; e_err = 0; e_inrst = 1;
      e_addr = '0; e_wdata = '0;
    end else begin
      e_inrst = 0;
      e_done  = m_term && !m_err;
      e_err   = m_term && m_err;
      xfer    = byte_valid && m_ready;
      e_we    = 0;
      if (xfer) begin
        m_rx.push_back(byte_data);
        n = m_rx.size();
        if (n >= 2) begin
          nw    = int'(m_rx[0]) | (int'(m_rx[1]) << 8);
          total = 2 + 4 * nw + (CS ? 1 : 0);
          if (nw > MAXW) begin
            m_term = 1; m_err = 1;
          end else begin
            if (n > 2 && n <= 2 + 4 * nw && (n - 2) % 4 == 0) begin
              e_we    = 1;
              e_addr  = AW'((n - 2) / 4 - 1);
              e_wdata = {m_rx[n-1], m_rx[n-2], m_rx[n-3], m_rx[n-4]};
            end
            if (n == total) begin
              m_term = 1;
              if (CS && byte_data != m_xor) m_err = 1;
            end
          end
        end
        m_xor = m_xor ^ byte_data;
      end
      m_ready = !m_term;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_started) begin
      chk("byte_ready", 32'(byte_ready), 32'(m_ready));
      chk("imem_we",    32'(imem_we),    32'(e_we));
      chk("load_done",  32'(load_done),  32'(e_done));
      chk("load_error", 32'(load_error), 32'(e_err));
      chk("core_rst_n", 32'(core_rst_n), 32'(e_done));
      if (e_we || e_inrst) begin
        chk("imem_addr",  32'(imem_addr), 32'(e_addr));
        chk("imem_wdata", imem_wdata,     e_wdata);
      end
    end
  end

  // Write log for the literal checks
  logic [31:0] wl_data[$];
  int          wl_addr[$];
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wl_data.push_back(imem_wdata);
      wl_addr.push_back(int'(imem_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    byte_valid = 1'b0;
    repeat (2) tick();
    wl_data.delete();
    wl_addr.delete();
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int guard;
    bit r;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    forever begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk);
      #1;
      if (r) break;
      guard++;
      if (guard > 20) begin
        checks++;
        errors++;
        $display("FAIL send_byte timeout actual=stalled expected=accept byte %h", b);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int maxgap, input bit add_csum);
    logic [7:0] x;
    x = 8'h00;
    foreach (s[i]) begin
      send_byte(s[i], maxgap);
      x = x ^ s[i];
    end
    if (CS && add_csum) send_byte(x, maxgap);
  endtask

  logic [7:0]  s2[$];
  logic [7:0]  st[$];
  logic [31:0] exp_w[$];

  initial begin
    int nw;
    logic [31:0] w;
    s2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    // 1: reset values, ready one cycle after release
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_byte_ready", 32'(byte_ready), 32'h0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'h0);
    chk("rst_imem_we",    32'(imem_we),    32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", 32'(byte_ready), 32'h1);

    // 2: two-word example, back to back
    do_reset();
    send_stream(s2, 0, 1'b1);
    repeat (3) tick();
    chk("ex_nwrites", 32'(wl_data.size()), 32'd2);
    if (wl_data.size() >= 2) begin
      chk("ex_w0", wl_data[0], 32'h00A00513);
      chk("ex_a0", 32'(wl_addr[0]), 32'd0);
      chk("ex_w1", wl_data[1], 32'h00100593);
      chk("ex_a1", 32'(wl_addr[1]), 32'd1);
    end
    chk("ex_done", 32'(load_done), 32'h1);
    chk("ex_core", 32'(core_rst_n), 32'h1);

    // 3: same stream with idle gaps
    do_reset();
    send_stream(s2, 3, 1'b1);
    repeat (3) tick();
    chk("gap_nwrites", 32'(wl_data.size()), 32'd2);
    if (wl_data.size() >= 2) begin
      chk("gap_w0", wl_data[0], 32'h00A00513);
      chk("gap_w1", wl_data[1], 32'h00100593);
    end

    // 4: oversize length 0x0101
    do_reset();
    st = '{8'h01, 8'h01};
    send_stream(st, 0, 1'b0);
    repeat (3) tick();
    chk("ovf_error", 32'(load_error), 32'h1);
    chk("ovf_ready", 32'(byte_ready), 32'h0);
    chk("ovf_core",  32'(core_rst_n), 32'h0);
    chk("ovf_nwr",   32'(wl_data.size()), 32'd0);

    // 5: reset mid-load, then a fresh one-word image
    do_reset();
    st = s2[0:5];
    send_stream(st, 0, 1'b0);
    do_reset();
    st = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(st, 1, 1'b1);
    repeat (3) tick();
    chk("rr_nwr", 32'(wl_data.size()), 32'd1);
    if (wl_data.size() >= 1) begin
      chk("rr_w0", wl_data[0], 32'hDEADBEEF);
      chk("rr_a0", 32'(wl_addr[0]), 32'd0);
    end
    chk("rr_done", 32'(load_done), 32'h1);

    // empty image
    do_reset();
    st = '{8'h00, 8'h00};
    send_stream(st, 0, 1'b1);
    repeat (3) tick();
    chk("empty_done", 32'(load_done), 32'h1);
    chk("empty_nwr",  32'(wl_data.size()), 32'd0);

    // random images
    for (int it = 0; it < 8; it++) begin
      do_reset();
      nw = int'($urandom_range(6, 1));
      st.delete();
      exp_w.delete();
      st.push_back(8'(nw));
      st.push_back(8'h00);
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        exp_w.push_back(w);
        for (int b = 0; b < 4; b++) st.push_back(8'(w >> (8 * b)));
      end
      send_stream(st, 2, 1'b1);
      repeat (3) tick();
      chk("rand_nwr", 32'(wl_data.size()), 32'(nw));
      for (int k = 0; k < nw && k < wl_data.size(); k++) begin
        chk("rand_word", wl_data[k], exp_w[k]);
        chk("rand_addr", 32'(wl_addr[k]), 32'(k));
      end
      chk("rand_done", 32'(load_done), 32'h1);
    end

    // full memory, N == 2**ADDR_WIDTH
    do_reset();
    st.delete();
    st.push_back(8'h00);
    st.push_back(8'h01);
    for (int k = 0; k < 4 * MAXW; k++) st.push_back(8'($urandom));
    send_stream(st, 0, 1'b1);
    repeat (3) tick();
    chk("full_nwr", 32'(wl_data.size()), 32'(MAXW));
    if (wl_data.size() == MAXW) chk("full_last_addr", 32'(wl_addr[MAXW-1]), 32'(MAXW - 1));
    chk("full_done", 32'(load_done), 32'h1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    st = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send_stream(st, 0, 1'b0);
    repeat (3) tick();
    chk("cs_ok_done", 32'(load_done), 32'h1);
    do_reset();
    st = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_stream(st, 0, 1'b0);
    repeat (3) tick();
    chk("cs_bad_err",  32'(load_error), 32'h1);
    chk("cs_bad_core", 32'(core_rst_n), 32'h0);
    chk("cs_bad_nwr",  32'(wl_data.size()), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
